// File: rtl/delay_pkg.sv
// Shared types and helpers for the programmable delay line.
// Pointer arithmetic stays modular without assuming a power-of-two depth.
package delay_pkg;

   typedef enum logic {
      FILL = 1'b0,
      RUN  = 1'b1
   } dly_state_t;

   // (a - b) mod modulus, for operands already in 0..modulus-1.
   function automatic int ptr_wrap_sub(input int a, input int b, input int modulus);
      if (a >= b)
         return a - b;
      else
         return a + modulus - b;
   endfunction

   function automatic int clamp_dly(input int req, input int max_dly);
      if (req < 1)
         return 1;
      else if (req > max_dly)
         return max_dly;
      else
         return req;
   endfunction

endpackage

// File: rtl/dly_regfile.sv
// Sample storage for the delay line: one write port, one asynchronous read port.
// Contents are intentionally not reset; the fill FSM hides stale entries.
module dly_regfile #(
   parameter int WIDTH  = 9,
   parameter int DEPTH  = 16,
   parameter int ADDR_W = 4
) (
   input  logic              clk,
   input  logic              we,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [WIDTH-1:0]  wr_data,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [WIDTH-1:0]  rd_data
);

   logic [WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we)
         mem[wr_addr] <= wr_data;
   end

   assign rd_data = mem[rd_addr];

endmodule

// File: rtl/delay_line_prog.sv
// Programmable-latency delay line: circular buffer plus fill FSM that blanks
// the output until D fresh samples have been written after reset or reload.
module delay_line_prog
   import delay_pkg::*;
#(
   parameter int DATA_W  = 8,
   parameter int MAX_DLY = 16,
   parameter int DEF_DLY = 4,
   parameter int DLY_W   = $clog2(MAX_DLY + 1)
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_en,
   input  logic              i_valid,
   input  logic [DATA_W-1:0] iv_data,
   input  logic              i_dly_load,
   input  logic [DLY_W-1:0]  iv_dly,
   output logic [DATA_W-1:0] ov_data,
   output logic              o_valid,
   output logic              o_busy,
   output logic [DLY_W-1:0]  ov_dly
);

   localparam int PTR_W = (MAX_DLY > 1) ? $clog2(MAX_DLY) : 1;
   localparam int ENT_W = DATA_W + 1;

   dly_state_t       state;
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_idx;
   logic [DLY_W-1:0] dly;
   logic [DLY_W-1:0] fill_cnt;
   logic [DLY_W-1:0] fill_next;
   logic [DLY_W-1:0] new_dly;
   logic [ENT_W-1:0] in_entry;
   logic [ENT_W-1:0] rd_entry;
   logic [ENT_W-1:0] dly_entry;

   assign in_entry  = {i_valid, iv_data};
   assign new_dly   = DLY_W'(clamp_dly(int'(iv_dly), MAX_DLY));
   assign fill_next = fill_cnt + DLY_W'(1);
   assign rd_idx    = PTR_W'(ptr_wrap_sub(int'(wr_ptr), int'(dly) - 1, MAX_DLY));

   // With D=1 the slot at rd_idx is the one being written this edge, so bypass.
   assign dly_entry = (dly == DLY_W'(1)) ? in_entry : rd_entry;

   dly_regfile #(
      .WIDTH  (ENT_W),
      .DEPTH  (MAX_DLY),
      .ADDR_W (PTR_W)
   ) u_regfile (
      .clk     (i_clk),
      .we      (i_en),
      .wr_addr (wr_ptr),
      .wr_data (in_entry),
      .rd_addr (rd_idx),
      .rd_data (rd_entry)
   );

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n)
         wr_ptr <= '0;
      else if (i_en)
         wr_ptr <= (wr_ptr == PTR_W'(MAX_DLY - 1)) ? '0 : wr_ptr + PTR_W'(1);
   end

   // A load wins over everything else, even with i_en low.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state    <= FILL;
         fill_cnt <= '0;
         dly      <= DLY_W'(DEF_DLY);
         ov_data  <= '0;
         o_valid  <= 1'b0;
         o_busy   <= 1'b1;
      end else if (i_dly_load) begin
         dly <= new_dly;
         if (i_en && (new_dly == DLY_W'(1))) begin
            state    <= RUN;
            fill_cnt <= DLY_W'(1);
            o_busy   <= 1'b0;
            o_valid  <= i_valid;
            ov_data  <= iv_data;
         end else begin
            state    <= FILL;
            fill_cnt <= i_en ? DLY_W'(1) : '0;
            o_busy   <= 1'b1;
            o_valid  <= 1'b0;
            ov_data  <= '0;
         end
      end else if (i_en) begin
         if (state == FILL) begin
            fill_cnt <= fill_next;
            if (fill_next == dly) begin
               state              <= RUN;
               o_busy             <= 1'b0;
               {o_valid, ov_data} <= dly_entry;
            end
         end else begin
            {o_valid, ov_data} <= dly_entry;
         end
      end
   end

   assign ov_dly = dly;

endmodule

// File: tb/tb_delay_line_prog.sv
// Directed self-checking bench for delay_line_prog with default parameters.
module tb_delay_line_prog;

   localparam int DATA_W  = 8;
   localparam int MAX_DLY = 16;
   localparam int DEF_DLY = 4;
   localparam int DLY_W   = $clog2(MAX_DLY + 1);

   logic              clk = 1'b0;
   logic              rst_n;
   logic              en;
   logic              valid;
   logic [DATA_W-1:0] data;
   logic              dly_load;
   logic [DLY_W-1:0]  dly_in;
   logic [DATA_W-1:0] ov_data;
   logic              o_valid;
   logic              o_busy;
   logic [DLY_W-1:0]  ov_dly;

   int check_cnt = 0;
   int pass_cnt  = 0;

   always #5 clk = ~clk;

   delay_line_prog #(
      .DATA_W  (DATA_W),
      .MAX_DLY (MAX_DLY),
      .DEF_DLY (DEF_DLY)
   ) dut (
      .i_clk      (clk),
      .i_rst_n    (rst_n),
      .i_en       (en),
      .i_valid    (valid),
      .iv_data    (data),
      .i_dly_load (dly_load),
      .iv_dly     (dly_in),
      .ov_data    (ov_data),
      .o_valid    (o_valid),
      .o_busy     (o_busy),
      .ov_dly     (ov_dly)
   );

   task automatic check_output(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      check_cnt++;
      if (actual === expected)
         pass_cnt++;
      else
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
   endtask

   task automatic check_state(input string tag, input logic exp_valid, input logic [DATA_W-1:0] exp_data,
                              input logic exp_busy);
      check_output({tag, ".valid"}, 32'(o_valid), 32'(exp_valid));
      check_output({tag, ".data"},  32'(ov_data), 32'(exp_data));
      check_output({tag, ".busy"},  32'(o_busy),  32'(exp_busy));
   endtask

   // Drives one cycle of inputs and returns #1 after the rising edge.
   task automatic apply_stimulus(input logic e, input logic v, input logic [DATA_W-1:0] d,
                                 input logic ld, input logic [DLY_W-1:0] nd);
      en       = e;
      valid    = v;
      data     = d;
      dly_load = ld;
      dly_in   = nd;
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [DATA_W-1:0] exp_d;
      logic              exp_v;

      rst_n = 1'b0; en = 1'b0; valid = 1'b0; data = '0; dly_load = 1'b0; dly_in = '0;
      repeat (2) @(posedge clk);
      #1;
      check_state("reset", 1'b0, 8'h00, 1'b1);
      check_output("reset.dly", 32'(ov_dly), 32'(DEF_DLY));
      rst_n = 1'b1;

      $display("[TB] default delay after reset");
      for (int e = 1; e <= 10; e++) begin
         apply_stimulus(1'b1, 1'b1, DATA_W'(e - 1), 1'b0, '0);
         exp_v = (e >= 4);
         exp_d = (e >= 4) ? DATA_W'(e - 4) : 8'h00;
         check_state($sformatf("def.e%0d", e), exp_v, exp_d, !exp_v);
      end

      $display("[TB] reload to 1");
      apply_stimulus(1'b1, 1'b1, 8'h77, 1'b1, 5'd1);
      check_state("d1.load", 1'b1, 8'h77, 1'b0);
      check_output("d1.dly", 32'(ov_dly), 32'd1);
      apply_stimulus(1'b1, 1'b1, 8'h78, 1'b0, '0);
      check_state("d1.next", 1'b1, 8'h78, 1'b0);

      $display("[TB] clamping");
      apply_stimulus(1'b1, 1'b1, 8'h32, 1'b1, 5'd0);
      check_output("clamp0.dly", 32'(ov_dly), 32'd1);
      check_state("clamp0", 1'b1, 8'h32, 1'b0);
      for (int e = 1; e <= 36; e++) begin
         apply_stimulus(1'b1, 1'b1, DATA_W'(100 + e - 1), (e == 1), 5'd31);
         if (e == 1)
            check_output("clamp31.dly", 32'(ov_dly), 32'(MAX_DLY));
         exp_v = (e >= 16);
         exp_d = (e >= 16) ? DATA_W'(100 + e - 16) : 8'h00;
         check_state($sformatf("clamp31.e%0d", e), exp_v, exp_d, !exp_v);
      end

      $display("[TB] enable gaps at D=3");
      apply_stimulus(1'b0, 1'b1, 8'hEE, 1'b1, 5'd3);
      check_state("gap.load", 1'b0, 8'h00, 1'b1);
      check_output("gap.dly", 32'(ov_dly), 32'd3);
      apply_stimulus(1'b1, 1'b1, 8'hA1, 1'b0, '0);
      check_state("gap.s1", 1'b0, 8'h00, 1'b1);
      apply_stimulus(1'b0, 1'b1, 8'hEE, 1'b0, '0);
      check_state("gap.s2", 1'b0, 8'h00, 1'b1);
      apply_stimulus(1'b1, 1'b1, 8'hB2, 1'b0, '0);
      check_state("gap.s3", 1'b0, 8'h00, 1'b1);
      apply_stimulus(1'b1, 1'b1, 8'hC3, 1'b0, '0);
      check_state("gap.s4", 1'b1, 8'hA1, 1'b0);
      apply_stimulus(1'b0, 1'b0, 8'hEE, 1'b0, '0);
      check_state("gap.s5", 1'b1, 8'hA1, 1'b0);
      apply_stimulus(1'b1, 1'b1, 8'hD4, 1'b0, '0);
      check_state("gap.s6", 1'b1, 8'hB2, 1'b0);

      $display("[TB] valid holes at D=5");
      for (int e = 1; e <= 10; e++) begin
         apply_stimulus(1'b1, (e != 2), DATA_W'(8'h10 + e - 1), (e == 1), 5'd5);
         exp_v = (e >= 5) && (e != 6);
         exp_d = (e >= 5) ? DATA_W'(8'h10 + e - 5) : 8'h00;
         check_state($sformatf("hole.e%0d", e), exp_v, exp_d, (e < 5));
      end

      $display("[TB] reload during fill, then reset");
      apply_stimulus(1'b1, 1'b1, 8'h40, 1'b1, 5'd8);
      check_output("rl.dly8", 32'(ov_dly), 32'd8);
      for (int e = 2; e <= 4; e++) begin
         apply_stimulus(1'b1, 1'b1, DATA_W'(8'h40 + e - 1), 1'b0, '0);
         check_state($sformatf("rl.fill%0d", e), 1'b0, 8'h00, 1'b1);
      end
      apply_stimulus(1'b1, 1'b1, 8'h50, 1'b1, 5'd2);
      check_state("rl.load2", 1'b0, 8'h00, 1'b1);
      check_output("rl.dly2", 32'(ov_dly), 32'd2);
      apply_stimulus(1'b1, 1'b1, 8'h51, 1'b0, '0);
      check_state("rl.run1", 1'b1, 8'h50, 1'b0);
      apply_stimulus(1'b1, 1'b1, 8'h52, 1'b0, '0);
      check_state("rl.run2", 1'b1, 8'h51, 1'b0);

      #2 rst_n = 1'b0;
      #1;
      check_state("arst", 1'b0, 8'h00, 1'b1);
      check_output("arst.dly", 32'(ov_dly), 32'(DEF_DLY));

      $display("%0d/%0d checks passed", pass_cnt, check_cnt);
      $finish;
   end

endmodule
